// File: rtl/priv_isa_types_pkg.sv
// priv_isa_types_pkg: trap source bit indices, cause codes, FSM states.
// Shared by trap_prio_enc and priv_trap_sequencer.
package priv_isa_types_pkg;

  localparam int unsigned N_EXC = 14;

  typedef enum int unsigned {
    SRC_INSN_MISALIGN  = 0,
    SRC_INSN_FAULT     = 1,
    SRC_ILLEGAL        = 2,
    SRC_BREAKPOINT     = 3,
    SRC_LOAD_MISALIGN  = 4,
    SRC_LOAD_FAULT     = 5,
    SRC_STORE_MISALIGN = 6,
    SRC_STORE_FAULT    = 7,
    SRC_ECALL_U        = 8,
    SRC_ECALL_S        = 9,
    SRC_ECALL_M        = 10,
    SRC_INSN_PF        = 11,
    SRC_LOAD_PF        = 12,
    SRC_STORE_PF       = 13
  } trap_src_t;

  localparam logic [4:0] CAUSE_INSN_MISALIGN  = 5'd0;
  localparam logic [4:0] CAUSE_INSN_FAULT     = 5'd1;
  localparam logic [4:0] CAUSE_ILLEGAL        = 5'd2;
  localparam logic [4:0] CAUSE_BREAKPOINT     = 5'd3;
  localparam logic [4:0] CAUSE_LOAD_MISALIGN  = 5'd4;
  localparam logic [4:0] CAUSE_LOAD_FAULT     = 5'd5;
  localparam logic [4:0] CAUSE_STORE_MISALIGN = 5'd6;
  localparam logic [4:0] CAUSE_STORE_FAULT    = 5'd7;
  localparam logic [4:0] CAUSE_ECALL_U        = 5'd8;
  localparam logic [4:0] CAUSE_ECALL_S        = 5'd9;
  localparam logic [4:0] CAUSE_ECALL_M        = 5'd11;
  localparam logic [4:0] CAUSE_INSN_PF        = 5'd12;
  localparam logic [4:0] CAUSE_LOAD_PF        = 5'd13;
  localparam logic [4:0] CAUSE_STORE_PF       = 5'd15;

  localparam logic [4:0] CAUSE_M_SOFT  = 5'd3;
  localparam logic [4:0] CAUSE_M_TIMER = 5'd7;
  localparam logic [4:0] CAUSE_M_EXT   = 5'd11;

  // irq_pend / irq_en bit positions: {ext, soft, timer}
  localparam int unsigned IRQ_TIMER = 0;
  localparam int unsigned IRQ_SOFT  = 1;
  localparam int unsigned IRQ_EXT   = 2;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    COMMIT,
    REDIRECT
  } trap_state_t;

  function automatic logic is_ecall(input logic [4:0] code);
    return (code == CAUSE_ECALL_U) ||
           (code == CAUSE_ECALL_S) ||
           (code == CAUSE_ECALL_M);
  endfunction

endpackage

// File: rtl/trap_prio_enc.sv
// trap_prio_enc: fixed-priority trap encoder, exceptions before interrupts.
// In: exc_flags, gated irq_act {ext,soft,timer}. Out: valid, irq, code.
module trap_prio_enc
  import priv_isa_types_pkg::*;
(
  input  logic [N_EXC-1:0] exc_flags,
  input  logic [2:0]       irq_act,
  output logic             valid,
  output logic             irq,
  output logic [4:0]       code
);

  always_comb begin
    valid = 1'b1;
    irq   = 1'b0;
    code  = 5'd0;
    priority case (1'b1)
      exc_flags[SRC_BREAKPOINT]:     code = CAUSE_BREAKPOINT;
      exc_flags[SRC_INSN_PF]:        code = CAUSE_INSN_PF;
      exc_flags[SRC_INSN_FAULT]:     code = CAUSE_INSN_FAULT;
      exc_flags[SRC_ILLEGAL]:        code = CAUSE_ILLEGAL;
      exc_flags[SRC_INSN_MISALIGN]:  code = CAUSE_INSN_MISALIGN;
      exc_flags[SRC_ECALL_M]:        code = CAUSE_ECALL_M;
      exc_flags[SRC_ECALL_S]:        code = CAUSE_ECALL_S;
      exc_flags[SRC_ECALL_U]:        code = CAUSE_ECALL_U;
      exc_flags[SRC_LOAD_MISALIGN]:  code = CAUSE_LOAD_MISALIGN;
      exc_flags[SRC_STORE_MISALIGN]: code = CAUSE_STORE_MISALIGN;
      exc_flags[SRC_LOAD_PF]:        code = CAUSE_LOAD_PF;
      exc_flags[SRC_STORE_PF]:       code = CAUSE_STORE_PF;
      exc_flags[SRC_LOAD_FAULT]:     code = CAUSE_LOAD_FAULT;
      exc_flags[SRC_STORE_FAULT]:    code = CAUSE_STORE_FAULT;
      irq_act[IRQ_EXT]: begin
        irq  = 1'b1;
        code = CAUSE_M_EXT;
      end
      irq_act[IRQ_SOFT]: begin
        irq  = 1'b1;
        code = CAUSE_M_SOFT;
      end
      irq_act[IRQ_TIMER]: begin
        irq  = 1'b1;
        code = CAUSE_M_TIMER;
      end
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/priv_trap_sequencer.sv
// priv_trap_sequencer: latch trap/xRET, drain, commit CSRs, redirect fetch.
// Out: trap_commit+cause/tval/epc, insert_pc+priv_pc, intr. Option: VECTORED_INTR_EN
module priv_trap_sequencer
  import priv_isa_types_pkg::*;
#(
  parameter int unsigned DRAIN_MAX = 15
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [13:0] exc_flags,
  input  logic [2:0]  irq_pend,
  input  logic [2:0]  irq_en,
  input  logic        mie_global,
  input  logic        mret,
  input  logic        sret,
  input  logic        pipe_clear,
  input  logic [31:0] epc,
  input  logic [31:0] badaddr,
  input  logic [31:0] xtvec,
  input  logic [31:0] xepc_r,
  output logic        insert_pc,
  output logic [31:0] priv_pc,
  output logic        intr,
  output logic        trap_commit,
  output logic [31:0] cause_o,
  output logic [31:0] tval_o,
  output logic [31:0] epc_o,
  output logic        drain_timeout
);

  logic [2:0]  irq_act;
  logic        enc_valid;
  logic        enc_irq;
  logic [4:0]  enc_code;
  logic        req;
  trap_state_t state;
  logic [3:0]  cnt;
  logic [3:0]  cnt_inc;
  logic        timeout_hit;
  logic        trap_l;
  logic        irq_l;
  logic [4:0]  code_l;
  logic [31:0] epc_l;
  logic [31:0] tval_l;
  logic [31:0] base;
  logic [31:0] vec_pc;

  assign irq_act = irq_pend & irq_en & {3{mie_global}};
  assign req     = enc_valid | mret | sret;

  trap_prio_enc u_enc (
    .exc_flags (exc_flags),
    .irq_act   (irq_act),
    .valid     (enc_valid),
    .irq       (enc_irq),
    .code      (enc_code)
  );

  assign cnt_inc     = (cnt == 4'hF) ? cnt : cnt + 4'd1;
  assign timeout_hit = 32'(cnt_inc) >= DRAIN_MAX;

  assign base = {xtvec[31:2], 2'b00};
`ifdef VECTORED_INTR_EN
  assign vec_pc = (irq_l && xtvec[1:0] == 2'b01)
                ? base + {25'd0, code_l, 2'b00}
                : base;
`else
  logic [1:0] unused_mode;
  assign unused_mode = xtvec[1:0];
  assign vec_pc      = base;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state         <= IDLE;
      cnt           <= '0;
      trap_l        <= 1'b0;
      irq_l         <= 1'b0;
      code_l        <= '0;
      epc_l         <= '0;
      tval_l        <= '0;
      insert_pc     <= 1'b0;
      priv_pc       <= '0;
      intr          <= 1'b0;
      trap_commit   <= 1'b0;
      cause_o       <= '0;
      tval_o        <= '0;
      epc_o         <= '0;
      drain_timeout <= 1'b0;
    end else begin
      trap_commit <= 1'b0;
      insert_pc   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            state  <= DRAIN;
            cnt    <= '0;
            trap_l <= enc_valid;
            intr   <= enc_valid;
            irq_l  <= enc_irq;
            code_l <= enc_code;
            epc_l  <= epc;
            // interrupts and ecalls carry no faulting address
            tval_l <= (enc_valid && !enc_irq && !is_ecall(enc_code))
                    ? badaddr : '0;
          end
        end
        DRAIN: begin
          cnt <= cnt_inc;
          if (pipe_clear || timeout_hit) begin
            state <= COMMIT;
            if (!pipe_clear) drain_timeout <= 1'b1;
            if (trap_l) begin
              trap_commit <= 1'b1;
              cause_o     <= {irq_l, 26'd0, code_l};
              tval_o      <= tval_l;
              epc_o       <= epc_l;
            end
          end
        end
        COMMIT: begin
          state     <= REDIRECT;
          insert_pc <= 1'b1;
          priv_pc   <= trap_l ? vec_pc : xepc_r;
        end
        REDIRECT: begin
          state <= IDLE;
          intr  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_priv_trap_sequencer.sv
// tb_priv_trap_sequencer: directed + random sequences vs a table-driven model.
// Checks commit/redirect timing, cause/tval/epc, priv_pc, intr, timeout, reset.
module tb_priv_trap_sequencer;

  localparam int DMAX = 15;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [13:0] exc_flags;
  logic [2:0]  irq_pend;
  logic [2:0]  irq_en;
  logic        mie_global;
  logic        mret;
  logic        sret;
  logic        pipe_clear;
  logic [31:0] epc;
  logic [31:0] badaddr;
  logic [31:0] xtvec;
  logic [31:0] xepc_r;
  logic        insert_pc;
  logic [31:0] priv_pc;
  logic        intr;
  logic        trap_commit;
  logic [31:0] cause_o;
  logic [31:0] tval_o;
  logic [31:0] epc_o;
  logic        drain_timeout;

  int checks = 0;
  int passed = 0;
  bit sticky_to = 1'b0;

  // exception priority, highest first: source bit and its cause code
  int unsigned exc_bit [14] = '{3, 11, 1, 2, 0, 10, 9, 8, 4, 6, 12, 13, 5, 7};
  int unsigned exc_code[14] = '{3, 12, 1, 2, 0, 11, 9, 8, 4, 6, 13, 15, 5, 7};

  priv_trap_sequencer #(.DRAIN_MAX(DMAX)) dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .exc_flags     (exc_flags),
    .irq_pend      (irq_pend),
    .irq_en        (irq_en),
    .mie_global    (mie_global),
    .mret          (mret),
    .sret          (sret),
    .pipe_clear    (pipe_clear),
    .epc           (epc),
    .badaddr       (badaddr),
    .xtvec         (xtvec),
    .xepc_r        (xepc_r),
    .insert_pc     (insert_pc),
    .priv_pc       (priv_pc),
    .intr          (intr),
    .trap_commit   (trap_commit),
    .cause_o       (cause_o),
    .tval_o        (tval_o),
    .epc_o         (epc_o),
    .drain_timeout (drain_timeout)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    assert (got === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [13:0] exc, input logic [2:0] pend,
                       input logic [2:0] en, input logic mie,
                       input logic m, input logic s,
                       input logic [31:0] bad, input logic [31:0] xtv,
                       input logic [31:0] xep,
                       output bit act, output bit trap,
                       output logic [31:0] cause, output logic [31:0] tval,
                       output logic [31:0] pc);
    logic [2:0]  g;
    logic [31:0] b;
    int unsigned code;
    act   = 1'b0;
    trap  = 1'b0;
    cause = '0;
    tval  = '0;
    code  = 0;
    g     = pend & en & {3{mie}};
    b     = {xtv[31:2], 2'b00};
    pc    = b;
    if (exc != 0) begin
      for (int i = 0; i < 14; i++)
        if (!trap && exc[exc_bit[i]]) begin
          trap = 1'b1;
          code = exc_code[i];
        end
      cause = code;
      tval  = (code == 8 || code == 9 || code == 11) ? 32'd0 : bad;
    end else if (g != 0) begin
      trap  = 1'b1;
      code  = g[2] ? 11 : (g[1] ? 3 : 7);
      cause = 32'h8000_0000 + code;
`ifdef VECTORED_INTR_EN
      if (xtv[1:0] == 2'b01) pc = b + 4 * code;
`endif
    end else if (m || s) begin
      pc = xep;
    end
    act = trap || m || s;
  endtask

  task automatic run_seq(input string tag, input logic [13:0] exc,
                         input logic [2:0] pend, input logic [2:0] en,
                         input logic mie, input logic m, input logic s,
                         input logic [31:0] pc_in, input logic [31:0] bad,
                         input logic [31:0] xtv, input logic [31:0] xep,
                         input int clear_at, input bit junk);
    bit          act, trap;
    logic [31:0] e_cause, e_tval, e_pc;
    logic [31:0] g_cause, g_tval, g_epc, g_pc;
    int          m_cyc, n_commit, c_cyc, n_ins, i_cyc, intr_bad;
    model(exc, pend, en, mie, m, s, bad, xtv, xep,
          act, trap, e_cause, e_tval, e_pc);
    n_commit = 0; c_cyc = 0; n_ins = 0; i_cyc = 0; intr_bad = 0;
    g_cause = '0; g_tval = '0; g_epc = '0; g_pc = '0;
    m_cyc = (clear_at >= 1 && clear_at <= DMAX) ? clear_at : DMAX;
    @(negedge CLK);
    exc_flags  = exc;
    irq_pend   = pend;
    irq_en     = en;
    mie_global = mie;
    mret       = m;
    sret       = s;
    epc        = pc_in;
    badaddr    = bad;
    xtvec      = xtv;
    xepc_r     = xep;
    pipe_clear = 1'b0;
    @(posedge CLK);
    #1;
    check({tag, " intr0"}, intr, trap);
    for (int c = 1; c <= 20; c++) begin
      @(negedge CLK);
      if (junk && act && c <= m_cyc + 2) begin
        exc_flags = 14'($urandom);
        irq_pend  = 3'($urandom);
        mret      = 1'($urandom);
        sret      = 1'($urandom);
        epc       = $urandom;
        badaddr   = $urandom;
      end else begin
        exc_flags = '0;
        irq_pend  = '0;
        mret      = 1'b0;
        sret      = 1'b0;
      end
      pipe_clear = (clear_at != 0 && c >= clear_at);
      @(posedge CLK);
      #1;
      if (trap_commit) begin
        n_commit++;
        c_cyc   = c;
        g_cause = cause_o;
        g_tval  = tval_o;
        g_epc   = epc_o;
      end
      if (insert_pc) begin
        n_ins++;
        i_cyc = c;
        g_pc  = priv_pc;
      end
      if (intr !== (trap && c <= m_cyc + 1)) intr_bad++;
    end
    pipe_clear = 1'b0;
    if (act && !(clear_at >= 1 && clear_at <= DMAX)) sticky_to = 1'b1;
    check({tag, " n_commit"}, n_commit, trap ? 1 : 0);
    if (trap) begin
      check({tag, " commit_cyc"}, c_cyc, m_cyc);
      check({tag, " cause"}, g_cause, e_cause);
      check({tag, " tval"}, g_tval, e_tval);
      check({tag, " epc"}, g_epc, pc_in);
    end
    check({tag, " n_insert"}, n_ins, act ? 1 : 0);
    if (act) begin
      check({tag, " insert_cyc"}, i_cyc, m_cyc + 1);
      check({tag, " priv_pc"}, g_pc, e_pc);
    end
    check({tag, " intr_bad"}, intr_bad, 0);
    check({tag, " drain_timeout"}, drain_timeout, sticky_to);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " insert_pc"}, insert_pc, 0);
    check({tag, " priv_pc"}, priv_pc, 0);
    check({tag, " intr"}, intr, 0);
    check({tag, " trap_commit"}, trap_commit, 0);
    check({tag, " cause_o"}, cause_o, 0);
    check({tag, " tval_o"}, tval_o, 0);
    check({tag, " epc_o"}, epc_o, 0);
    check({tag, " drain_timeout"}, drain_timeout, 0);
  endtask

  initial begin
    int n_bad;
    int ca;
    nRST       = 1'b0;
    exc_flags  = '0;
    irq_pend   = '0;
    irq_en     = '0;
    mie_global = 1'b0;
    mret       = 1'b0;
    sret       = 1'b0;
    pipe_clear = 1'b0;
    epc        = '0;
    badaddr    = '0;
    xtvec      = '0;
    xepc_r     = '0;
    #12;
    check_zero("reset");
    @(negedge CLK);
    nRST = 1'b1;

    run_seq("illegal", 14'h0004, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0,
            32'h100, 32'hDEAD_BEEF, 32'h8000_0000, 32'h0, 2, 1'b0);
    run_seq("bkpt_ldf", 14'h0028, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0,
            32'h204, 32'h1234_5678, 32'h8000_0000, 32'h0, 1, 1'b0);
    run_seq("ecall", 14'h0400, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0,
            32'h300, 32'hFFFF_0000, 32'h8000_0100, 32'h0, 3, 1'b0);
    run_seq("timer", 14'h0000, 3'b001, 3'b001, 1'b1, 1'b0, 1'b0,
            32'h400, 32'hAAAA_5555, 32'h8000_0001, 32'h0, 2, 1'b0);
    run_seq("ext_timer", 14'h0000, 3'b101, 3'b111, 1'b1, 1'b0, 1'b0,
            32'h404, 32'h0, 32'h8000_0001, 32'h0, 4, 1'b0);
    run_seq("mie_off", 14'h0000, 3'b111, 3'b111, 1'b0, 1'b0, 1'b0,
            32'h408, 32'h0, 32'h8000_0000, 32'h0, 1, 1'b0);
    run_seq("mret", 14'h0000, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0,
            32'h500, 32'h0, 32'h8000_0000, 32'h2000, 2, 1'b0);
    run_seq("exc_vs_mret", 14'h2000, 3'b010, 3'b010, 1'b1, 1'b1, 1'b1,
            32'h600, 32'h7000, 32'h8000_0000, 32'h3000, 5, 1'b0);
    run_seq("timeout", 14'h0004, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0,
            32'h700, 32'h44, 32'h9000_0000, 32'h0, 0, 1'b0);

    // reset asserted mid-DRAIN: immediate clear, no commit afterwards
    @(negedge CLK);
    exc_flags = 14'h0004;
    epc       = 32'h800;
    badaddr   = 32'h55;
    @(posedge CLK);
    #1;
    exc_flags = '0;
    repeat (2) @(posedge CLK);
    #3;
    nRST = 1'b0;
    #1;
    check_zero("mid_rst");
    sticky_to = 1'b0;
    @(negedge CLK);
    nRST       = 1'b1;
    pipe_clear = 1'b1;
    n_bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge CLK);
      #1;
      if (trap_commit || insert_pc || intr) n_bad++;
    end
    check("post_rst activity", n_bad, 0);
    pipe_clear = 1'b0;

    for (int i = 0; i < 40; i++) begin
      ca = $urandom_range(0, 15);
      if (ca == 15) ca = 0;
      run_seq("rand",
              ($urandom_range(0, 2) == 0) ? 14'($urandom & $urandom) : 14'd0,
              3'($urandom), 3'($urandom), 1'($urandom),
              1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
              $urandom, $urandom,
              {$urandom_range(0, 32'h3FFF_FFFF), 1'b0, 1'($urandom)},
              $urandom, ca, 1'b1);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/priv_trap_sequencer.md
PRIV_TRAP_SEQUENCER -- requirements
Module: priv_trap_sequencer

Interface
REQ-001 SHALL have parameter DRAIN_MAX, default 15: maximum cycles spent waiting for pipe_clear before a forced commit.
REQ-002 SHALL have port CLK, input, 1: clock; all state updates on its rising edge.
REQ-003 SHALL have port nRST, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port exc_flags, input, 14: synchronous exception requests, bit order per trap_src_t.
REQ-005 SHALL have port irq_pend, input, 3: {ext, soft, timer} pending.
REQ-006 SHALL have port irq_en, input, 3: per-source enable.
REQ-007 SHALL have port mie_global, input, 1: mstatus.mie.
REQ-008 SHALL have ports mret and sret, input, 1 each: return requests.
REQ-009 SHALL have port pipe_clear, input, 1: pipeline drained.
REQ-010 SHALL have ports epc and badaddr, input, 32 each: faulting PC and address.
REQ-011 SHALL have ports xtvec and xepc_r, input, 32 each: M-mode trap vector and return PC.
REQ-012 SHALL have ports insert_pc, output, 1, and priv_pc, output, 32: fetch redirect.
REQ-013 SHALL have port intr, output, 1: trap in progress.
REQ-014 SHALL have port trap_commit, output, 1: one-cycle CSR write strobe.
REQ-015 SHALL have ports cause_o, tval_o and epc_o, output, 32 each: CSR write data.
REQ-016 SHALL have port drain_timeout, output, 1: sticky flag.

Function
REQ-017 FSM states SHALL be IDLE, DRAIN, COMMIT, REDIRECT.
REQ-018 In IDLE, any exc_flags bit, enabled interrupt (irq_pend & irq_en, gated by mie_global), mret or sret SHALL latch the request and move to DRAIN on the next edge.
REQ-019 Exception priority SHALL be fixed: breakpoint > insn page fault > insn fault > illegal > insn misaligned > ecall > load/store misaligned > load/store page fault > load/store fault.
REQ-020 Interrupt priority SHALL be ext (11) > soft (3) > timer (7).
REQ-021 Simultaneous requests SHALL resolve as exception > interrupt > mret > sret.
REQ-022 In DRAIN, a saturating 4-bit counter SHALL increment each cycle.
REQ-023 pipe_clear SHALL move DRAIN to COMMIT.
REQ-024 Counter reaching DRAIN_MAX SHALL move DRAIN to COMMIT and set drain_timeout.
REQ-025 In COMMIT, trap_commit SHALL be 1 for exactly one cycle with cause_o = {irq, 26'b0, code[4:0]}, tval_o = latched badaddr (0 for interrupts and ecall), epc_o = latched epc; mret and sret SHALL NOT assert trap_commit.
REQ-026 In REDIRECT, insert_pc SHALL be 1 for one cycle with priv_pc = {xtvec[31:2], 2'b00} for traps and xepc_r for mret/sret; the FSM then returns to IDLE.
REQ-027 intr SHALL be 1 in DRAIN, COMMIT and REDIRECT for traps only.
REQ-028 Requests arriving outside IDLE SHALL be ignored; inputs that are still asserted are re-sampled on return to IDLE.
REQ-029 Latched cause, epc and badaddr SHALL be held stable from the DRAIN entry edge until IDLE.

Reset
REQ-030 nRST low SHALL force IDLE and clear the counter and all outputs (priv_pc, cause_o, tval_o and epc_o = 0; strobes = 0; drain_timeout = 0) immediately, even mid-sequence.
REQ-031 A trap interrupted by reset SHALL be lost, with no partial trap_commit.

Configuration
REQ-032 With VECTORED_INTR_EN defined, xtvec[1:0] = 01 and an interrupt cause SHALL give priv_pc = base + 4*code; exceptions SHALL always use base.
REQ-033 Without VECTORED_INTR_EN, xtvec[1:0] SHALL be ignored and all traps SHALL use base.

Structure
REQ-034 trap_src_t bit indices, the cause-code constants and the FSM state enum SHALL live in priv_isa_types_pkg.
REQ-035 The fixed-priority encoder SHALL be sub-module trap_prio_enc (combinational, returns valid, irq and code).

Verification
REQ-036 Illegal bit set with epc=0x100, xtvec=0x8000_0000, pipe_clear after 2 cycles SHALL produce trap_commit with cause 0x2 and epc_o 0x100, then insert_pc with priv_pc 0x8000_0000.
REQ-037 Breakpoint and load fault set together SHALL yield cause 0x3.
REQ-038 Timer interrupt enabled, mie_global=1, with VECTORED_INTR_EN and xtvec=0x8000_0001 SHALL yield cause 0x8000_0007, tval 0, priv_pc 0x8000_001C.
REQ-039 pipe_clear never asserted SHALL cause forced COMMIT after 15 DRAIN cycles with drain_timeout=1.
REQ-040 mret with xepc_r=0x2000 SHALL produce no trap_commit and insert_pc with priv_pc 0x2000.
REQ-041 nRST low during DRAIN SHALL return to IDLE immediately with no trap_commit and all outputs 0.
